// File: rtl/ysyx_25040101_defs.sv
// Shared definitions for the fetch-side blocks: responder state encoding,
// the core reset vector and small address helpers.
package ysyx_25040101_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  // True when a byte offset from the array base lands inside a 2**depth_log2-word array.
  function automatic logic off_in_range(input logic [31:0] off, input int unsigned depth_log2);
    return {1'b0, off} < (33'd1 << (depth_log2 + 2));
  endfunction

endpackage

// File: rtl/ysyx_25040101_imem_resp_if.sv
// Fetch channel between the core (master) and an instruction responder (slave):
// a valid/ready request carrying a byte address and a valid/ready response.
interface ysyx_25040101_imem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_25040101_sram_array.sv
// Word-wide storage with a registered read port and a byte-strobed write port.
// A read and a write to the same word on one edge return the old contents.
module ysyx_25040101_sram_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb
);

  logic [31:0] mem [2**AW];
  logic [31:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_25040101_imem_resp.sv
// Instruction-memory responder: accepts one fetch at a time, waits LATENCY
// cycles, then returns the addressed word (or an access fault) until consumed.
module ysyx_25040101_imem_resp
  import ysyx_25040101_defs::*;
#(
  parameter logic [31:0] ADDR_BASE  = RESET_VEC,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_25040101_imem_resp_if.slave    bus,
  input  logic                        wr_en,
  input  logic [31:0]                 wr_addr,
  input  logic [31:0]                 wr_data,
  input  logic [3:0]                  wr_strb
);

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("ysyx_25040101_imem_resp: LATENCY must be within 0..15");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 29) begin : g_bad_depth
      $error("ysyx_25040101_imem_resp: DEPTH_LOG2 must be within 1..29");
    end
  endgenerate

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  imem_state_e state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] addr_reg;
  logic        err_reg;
  logic        data_ok_reg;

  logic [31:0]           rd_sel_addr;
  logic [31:0]           rd_off;
  logic                  rd_fault;
  logic                  capture;
  logic [31:0]           wr_off;
  logic                  wr_ok;
  logic [31:0]           arr_rd_data;

  // With zero latency the capture happens on the acceptance edge, before addr_reg is loaded.
  assign rd_sel_addr = (state_reg == IDLE) ? bus.req_addr : addr_reg;
  assign rd_off      = rd_sel_addr - ADDR_BASE;
  assign rd_fault    = (rd_sel_addr[1:0] != 2'b00) || !off_in_range(rd_off, DEPTH_LOG2);
  assign capture     = (state_next == RESP) && (state_reg != RESP);

  assign wr_off = wr_addr - ADDR_BASE;
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && off_in_range(wr_off, DEPTH_LOG2);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            state_next = RESP;
          end else begin
            cnt_next   = LAT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      addr_reg    <= 32'd0;
      err_reg     <= 1'b0;
      data_ok_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && bus.req_valid) begin
        addr_reg <= bus.req_addr;
      end
      if (capture) begin
        err_reg     <= rd_fault;
        data_ok_reg <= !rd_fault;
      end
    end
  end

  ysyx_25040101_sram_array #(
    .AW(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .rd_en   (capture && !rd_fault),
    .rd_idx  (rd_off[DEPTH_LOG2+1:2]),
    .rd_data (arr_rd_data),
    .wr_en   (wr_ok),
    .wr_idx  (wr_off[DEPTH_LOG2+1:2]),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );

  // The array output has no reset, so data_ok_reg forces zero after reset and on faults.
  assign bus.rsp_data = data_ok_reg ? arr_rd_data : 32'h0000_0000;
  assign bus.rsp_err  = err_reg;

endmodule

// File: tb/tb_ysyx_25040101_imem_resp.sv
// Bench for the instruction responder: a LATENCY=2 instance driven from a vector
// table plus corner sequences, and a LATENCY=0 instance run back-to-back.
module tb_ysyx_25040101_imem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  always #5 clk = ~clk;

  ysyx_25040101_imem_resp_if m2 ();
  ysyx_25040101_imem_resp_if m0 ();

  ysyx_25040101_imem_resp #(
    .ADDR_BASE(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(2)
  ) u_lat2 (
    .clk(clk), .rst(rst), .bus(m2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  ysyx_25040101_imem_resp #(
    .ADDR_BASE(32'h8000_0000), .DEPTH_LOG2(12), .LATENCY(0)
  ) u_lat0 (
    .clk(clk), .rst(rst), .bus(m0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          hold;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  vec_t vecs0[5];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] d, input logic e);
    exp_t x;
    if (exp_q.size() == 0) begin
      chk({name, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      chk({name, "_data"}, d, x.data);
      chk({name, "_err"}, {31'd0, e}, {31'd0, x.err});
      $display("rsp %s data=%h err=%0b", name, d, e);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk); #1;
    wr_en = 1'b0;
    $display("write addr=%h data=%h strb=%b", a, d, s);
  endtask

  // One fetch on the LATENCY=2 instance; entered and left at posedge+1 in IDLE.
  task automatic fetch2(input logic [31:0] a, input logic [31:0] d, input logic e, input int hold);
    int n;
    chk("idle_req_ready", m2.req_ready, 1);
    m2.req_valid = 1'b1; m2.req_addr = a; m2.rsp_ready = (hold == 0);
    @(posedge clk); #1;
    exp_q.push_back('{err: e, data: d});
    m2.req_valid = 1'b0;
    n = 1;
    while (!m2.rsp_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_cycles", n, 3);
    for (int i = 0; i < hold; i++) begin
      chk("hold_rsp_valid", m2.rsp_valid, 1);
      chk("hold_rsp_data", m2.rsp_data, d);
      chk("hold_req_ready", m2.req_ready, 0);
      m2.req_valid = 1'b1; m2.req_addr = 32'h8000_0008;
      if (i < hold - 1) begin
        @(posedge clk); #1;
      end
    end
    m2.req_valid = 1'b0; m2.rsp_ready = 1'b1;
    chk("rsp_valid", m2.rsp_valid, 1);
    pop_chk("lat2", m2.rsp_data, m2.rsp_err);
    @(posedge clk); #1;
    chk("post_rsp_valid", m2.rsp_valid, 0);
    chk("post_req_ready", m2.req_ready, 1);
    m2.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, rsp_cnt, last_cyc;
    logic acc;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    m2.req_valid = 1'b0; m2.req_addr = '0; m2.rsp_ready = 1'b0;
    m0.req_valid = 1'b0; m0.req_addr = '0; m0.rsp_ready = 1'b0;

    vecs[0] = '{addr: 32'h8000_0000, data: 32'h0010_0093, err: 1'b0, hold: 0};
    vecs[1] = '{addr: 32'h8000_0004, data: 32'h0020_8113, err: 1'b0, hold: 5};
    vecs[2] = '{addr: 32'h8000_0002, data: 32'h0000_0000, err: 1'b1, hold: 0};
    vecs[3] = '{addr: 32'h7FFF_FFFC, data: 32'h0000_0000, err: 1'b1, hold: 0};
    vecs[4] = '{addr: 32'h8000_4000, data: 32'h0000_0000, err: 1'b1, hold: 0};
    vecs[5] = '{addr: 32'h8000_3FFC, data: 32'hDEAD_BEEF, err: 1'b0, hold: 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready_l2", m2.req_ready, 1);
    chk("rst_rsp_valid_l2", m2.rsp_valid, 0);
    chk("rst_rsp_data_l2", m2.rsp_data, 0);
    chk("rst_rsp_err_l2", m2.rsp_err, 0);
    chk("rst_req_ready_l0", m0.req_ready, 1);
    chk("rst_rsp_valid_l0", m0.rsp_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    wr(32'h8000_0000, 32'h0010_0093, 4'hF);
    wr(32'h8000_0004, 32'h0020_8113, 4'hF);
    wr(32'h8000_0008, 32'hAAAA_0001, 4'hF);
    wr(32'h8000_3FFC, 32'hDEAD_BEEF, 4'hF);
    // Dropped writes: would alias onto word0 / word1 if decode were wrong.
    wr(32'h8000_4000, 32'h1234_5678, 4'hF);
    wr(32'h8000_0006, 32'hFFFF_FFFF, 4'hF);

    for (int i = 0; i < 6; i++) begin
      fetch2(vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].hold);
    end

    wr(32'h8000_0000, 32'h0000_AB00, 4'b0010);
    fetch2(32'h8000_0000, 32'h0010_AB93, 1'b0, 0);

    // Write lands on the capture edge of the same word: old value returned.
    m2.req_valid = 1'b1; m2.req_addr = 32'h8000_0008; m2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{err: 1'b0, data: 32'hAAAA_0001});
    m2.req_valid = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 32'h8000_0008; wr_data = 32'h5555_0002; wr_strb = 4'hF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("rbw_rsp_valid", m2.rsp_valid, 1);
    pop_chk("rbw", m2.rsp_data, m2.rsp_err);
    @(posedge clk); #1;
    m2.rsp_ready = 1'b0;
    fetch2(32'h8000_0008, 32'h5555_0002, 1'b0, 0);

    // Reset asserted while waiting aborts the fetch.
    m2.req_valid = 1'b1; m2.req_addr = 32'h8000_0004; m2.rsp_ready = 1'b1;
    @(posedge clk); #1;
    m2.req_valid = 1'b0;
    chk("wait_req_ready", m2.req_ready, 0);
    chk("wait_rsp_data_held", m2.rsp_data, 32'h5555_0002);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req_ready", m2.req_ready, 1);
    chk("async_rst_rsp_valid", m2.rsp_valid, 0);
    chk("async_rst_rsp_data", m2.rsp_data, 0);
    chk("async_rst_rsp_err", m2.rsp_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_rsp_valid", m2.rsp_valid, 0);
      chk("abort_req_ready", m2.req_ready, 1);
      @(posedge clk); #1;
    end
    m2.rsp_ready = 1'b0;
    $display("reset during wait: request aborted");

    // LATENCY=0: back-to-back requests with rsp_ready held high.
    vecs0[0] = '{addr: 32'h8000_0000, data: 32'h0010_AB93, err: 1'b0, hold: 0};
    vecs0[1] = '{addr: 32'h8000_0004, data: 32'h0020_8113, err: 1'b0, hold: 0};
    vecs0[2] = '{addr: 32'h8000_0008, data: 32'h5555_0002, err: 1'b0, hold: 0};
    vecs0[3] = '{addr: 32'h8000_0001, data: 32'h0000_0000, err: 1'b1, hold: 0};
    vecs0[4] = '{addr: 32'h8000_3FFC, data: 32'hDEAD_BEEF, err: 1'b0, hold: 0};
    idx = 0; rsp_cnt = 0; last_cyc = -1;
    m0.rsp_ready = 1'b1; m0.req_valid = 1'b1; m0.req_addr = vecs0[0].addr;
    for (int cyc = 0; cyc < 40 && rsp_cnt < 5; cyc++) begin
      if (m0.rsp_valid) begin
        pop_chk("lat0", m0.rsp_data, m0.rsp_err);
        if (last_cyc >= 0) chk("lat0_period", cyc - last_cyc, 2);
        last_cyc = cyc;
        rsp_cnt++;
      end
      acc = m0.req_valid && m0.req_ready;
      if (acc) exp_q.push_back('{err: vecs0[idx].err, data: vecs0[idx].data});
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) m0.req_addr = vecs0[idx].addr;
        else m0.req_valid = 1'b0;
      end
    end
    chk("lat0_response_count", rsp_cnt, 5);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
